// File: rtl/tl_ul_loader_if.sv
// TileLink-UL A/D channel bundle between the stream loader (master) and a
// responder such as the switch or memory (slave).
interface tl_ul_loader_if #(
    parameter int XLEN      = 32,
    parameter int SID_WIDTH = 2
);
    logic                   a_valid;
    logic                   a_ready;
    logic [2:0]             a_opcode;
    logic [2:0]             a_param;
    logic [2:0]             a_size;
    logic [SID_WIDTH-1:0]   a_source;
    logic [XLEN-1:0]        a_address;
    logic [XLEN/8-1:0]      a_mask;
    logic [XLEN-1:0]        a_data;

    logic                   d_valid;
    logic                   d_ready;
    logic [2:0]             d_opcode;
    logic [SID_WIDTH-1:0]   d_source;
    logic                   d_denied;
    logic                   d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_source, d_denied, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_source, d_denied, d_corrupt,
        input  d_ready
    );
endinterface

// File: rtl/tl_ul_loader.sv
// Byte-stream to TileLink-UL PutFullData loader. Packs little-endian bytes
// into words and writes them to consecutive addresses, one write in flight.
module tl_ul_loader #(
    parameter int XLEN      = 32,
    parameter int SID_WIDTH = 2,
    parameter int SOURCE_ID = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [XLEN-1:0]     start_addr,
    input  logic [15:0]         word_count,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [7:0]          s_data,
    tl_ul_loader_if.master      tl,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [15:0]         words_written
);
    localparam int NBYTES = XLEN / 8;
    localparam int IDXW   = $clog2(NBYTES);
    localparam logic [IDXW-1:0]      LAST_IDX   = IDXW'(NBYTES - 1);
    localparam logic [XLEN-1:0]      ALIGN_MASK = ~(XLEN'(NBYTES - 1));
    localparam logic [SID_WIDTH-1:0] SRC        = SID_WIDTH'(SOURCE_ID);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_REQ     = 3'd2;
    localparam logic [2:0] S_RESP    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]      state;
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] data_q;
    logic [15:0]     count_q;
    logic [15:0]     ww_q;
    logic            err_q;
    logic            resp_bad;

    // d_corrupt carries no meaning for write acknowledgements
    logic unused_corrupt;
    assign unused_corrupt = tl.d_corrupt;

    assign resp_bad = tl.d_denied || (tl.d_opcode != 3'd0) || (tl.d_source != SRC);

    // Sequencer: collect bytes, issue one write, wait for its ack, repeat
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
            ww_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= start_addr & ALIGN_MASK;
                        count_q <= word_count;
                        err_q   <= 1'b0;
                        ww_q    <= '0;
                        idx     <= '0;
                        state   <= (word_count == 16'd0) ? S_DONE : S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if (s_valid) begin
                        data_q[{idx, 3'b000} +: 8] <= s_data;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= S_REQ;
                        end else begin
                            idx <= idx + IDXW'(1);
                        end
                    end
                end
                S_REQ: begin
                    if (tl.a_ready) state <= S_RESP;
                end
                S_RESP: begin
                    if (tl.d_valid) begin
                        if (resp_bad) begin
                            err_q <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            ww_q   <= ww_q + 16'd1;
                            addr_q <= addr_q + XLEN'(NBYTES);
                            state  <= (ww_q + 16'd1 == count_q) ? S_DONE : S_COLLECT;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake and status outputs decode only the state register
    assign s_ready       = (state == S_COLLECT);
    assign tl.a_valid    = (state == S_REQ);
    assign tl.d_ready    = (state == S_RESP);
    assign busy          = (state != S_IDLE);
    assign done          = (state == S_DONE);
    assign error         = err_q;
    assign words_written = ww_q;

    assign tl.a_opcode   = 3'd0;
    assign tl.a_param    = 3'd0;
    assign tl.a_size     = 3'(IDXW);
    assign tl.a_source   = SRC;
    assign tl.a_mask     = '1;
    assign tl.a_address  = addr_q;
    assign tl.a_data     = data_q;
endmodule

// File: tb/tb_tl_ul_loader.sv
// Directed bench for tl_ul_loader: a stall/deny-capable responder, an
// A-channel/done scoreboard monitor, and hand-computed expected writes.
module tb_tl_ul_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] start_addr = '0;
    logic [15:0] word_count = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        busy, done, error;
    logic [15:0] words_written;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { logic [31:0] addr; logic [31:0] data; } a_exp_t;
    a_exp_t aq[$];
    int     dq[$];

    // {opcode, param, size, mask, source}
    localparam logic [14:0] A_FIXED = {3'd0, 3'd0, 3'd2, 4'hF, 2'd1};

    tl_ul_loader_if #(.XLEN(32), .SID_WIDTH(2)) tl();

    tl_ul_loader #(.XLEN(32), .SID_WIDTH(2), .SOURCE_ID(1)) dut (
        .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
        .word_count(word_count), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .tl(tl), .busy(busy), .done(done), .error(error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Responder: a_ready after stall_cycles waits, immediate D response
    int stall_cycles = 0;
    int deny_idx = -1;
    int resp_count = 0;
    int stall_cnt = 0;
    logic [7:0] mem [0:255];
    initial begin
        logic [7:0] ma;
        tl.a_ready = 1'b0; tl.d_valid = 1'b0; tl.d_opcode = 3'd0;
        tl.d_source = 2'd1; tl.d_denied = 1'b0; tl.d_corrupt = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        forever begin
            @(negedge clk);
            tl.a_ready = 1'b0; tl.d_valid = 1'b0; tl.d_denied = 1'b0;
            if (!reset) begin
                stall_cnt = 0;
            end else begin
                if (tl.a_valid) begin
                    if (stall_cnt < stall_cycles) begin
                        stall_cnt++;
                    end else begin
                        stall_cnt = 0;
                        tl.a_ready = 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            ma = tl.a_address[7:0] + 8'(b);
                            mem[ma] = tl.a_data[8*b +: 8];
                        end
                    end
                end
                if (tl.d_ready) begin
                    tl.d_valid  = 1'b1;
                    tl.d_denied = (resp_count == deny_idx);
                    resp_count++;
                end
            end
        end
    end

    // Monitor: every cycle with a_valid must match the head expected write
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                if (tl.a_valid) begin
                    if (aq.size() == 0) begin
                        chk("a_unexpected", tl.a_valid, 0);
                    end else begin
                        chk("a_address", tl.a_address, aq[0].addr);
                        chk("a_data", tl.a_data, aq[0].data);
                        chk("a_fixed", {tl.a_opcode, tl.a_param, tl.a_size, tl.a_mask, tl.a_source}, A_FIXED);
                        if (tl.a_ready) void'(aq.pop_front());
                    end
                end
                if (done) begin
                    if (dq.size() == 0) chk("done_unexpected", done, 0);
                    else chk("done_words", words_written, dq.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic push_a(input logic [31:0] a, input logic [31:0] d);
        a_exp_t e;
        e.addr = a; e.data = d;
        aq.push_back(e);
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] n);
        start = 1'b1; start_addr = a; word_count = n;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_s_ready", s_ready, (n != 16'd0));
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (!s_ready && n < 200) begin @(negedge clk); n++; end
        if (!s_ready) begin
            chk("s_ready_timeout", s_ready, 1);
        end else begin
            s_valid = 1'b1; s_data = b;
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin @(negedge clk); n++; end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        int t0;
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_words", words_written, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_a_valid", tl.a_valid, 0);
        chk("rst_d_ready", tl.d_ready, 0);
        chk("rst_a_address", tl.a_address, 0);
        chk("rst_a_data", tl.a_data, 0);
        chk("rst_a_fixed", {tl.a_opcode, tl.a_param, tl.a_size, tl.a_mask, tl.a_source}, A_FIXED);
        reset = 1'b1;
        @(negedge clk);

        // Single word, zero wait: busy spans exactly 7 cycles
        push_a(32'h0000_0100, 32'h0000_0013);
        dq.push_back(1);
        t0 = cyc;
        do_start(32'h100, 16'd1);
        send_word(32'h0000_0013);
        wait_idle();
        chk("single_latency", cyc - t0, 8);
        chk("single_words", words_written, 1);
        chk("single_error", error, 0);
        chk("single_mem", mem[0], 8'h13);

        // Four words with a_ready held low 3 cycles per request
        stall_cycles = 3;
        push_a(32'h0, 32'h1312_1110);
        push_a(32'h4, 32'h1716_1514);
        push_a(32'h8, 32'h1B1A_1918);
        push_a(32'hC, 32'h1F1E_1D1C);
        dq.push_back(4);
        do_start(32'h0, 16'd4);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i));
        wait_idle();
        chk("multi_words", words_written, 4);
        chk("multi_error", error, 0);
        for (int i = 0; i < 16; i++) chk("multi_mem", mem[i], 8'(8'h10 + i));
        stall_cycles = 0;

        // Second of three words denied
        resp_count = 0;
        deny_idx = 1;
        push_a(32'h40, 32'hA3A2_A1A0);
        push_a(32'h44, 32'hB3B2_B1B0);
        do_start(32'h40, 16'd3);
        send_word(32'hA3A2_A1A0);
        send_word(32'hB3B2_B1B0);
        wait_idle();
        chk("deny_error", error, 1);
        chk("deny_words", words_written, 1);
        chk("deny_done", done, 0);
        deny_idx = -1;

        // Zero-length load: done in T+1, error cleared by the start
        dq.push_back(0);
        do_start(32'h200, 16'd0);
        chk("zero_done", done, 1);
        chk("zero_error_cleared", error, 0);
        @(negedge clk);
        chk("zero_idle", busy, 0);

        // Misaligned start address is rounded down
        push_a(32'h100, 32'hDDCC_BBAA);
        dq.push_back(1);
        do_start(32'h103, 16'd1);
        send_word(32'hDDCC_BBAA);
        wait_idle();
        chk("align_words", words_written, 1);

        // Address wraps past the top of the space
        push_a(32'hFFFF_FFFC, 32'h0403_0201);
        push_a(32'h0000_0000, 32'h0807_0605);
        dq.push_back(2);
        do_start(32'hFFFF_FFFC, 16'd2);
        send_word(32'h0403_0201);
        send_word(32'h0807_0605);
        wait_idle();
        chk("wrap_words", words_written, 2);

        // Reset in the middle of a word abandons it
        do_start(32'h20, 16'd4);
        send_byte(8'h55);
        send_byte(8'h66);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_a_valid", tl.a_valid, 0);
        chk("midrst_a_data", tl.a_data, 0);
        chk("midrst_words", words_written, 0);
        repeat (6) @(negedge clk);
        chk("midrst_mem", mem[8'h20], 8'h00);

        chk("aq_empty", aq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tl_ul_loader.md
# tl_ul_loader

TileLink-UL master that turns an incoming byte stream, typically from a UART receiver or a bench driver, into PutFullData writes. It fills memory with a program image before the CPU is released. It sits on a master input of `tl_ul_switch` beside the CPU, and it is the initiating end of the interface that `tl_ul_memory` responds to. It issues one word write at a time to consecutive addresses and reports completion or error.

## Interface
Parameters:
- XLEN, 32: data/address width; 32 or 64.
- SID_WIDTH, 2: TileLink source ID width.
- SOURCE_ID, 1: constant driven on a_source and expected on d_source.

Ports:
- Clock and reset: reset reset, synchronous, active-low; clock clk.
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled in IDLE only.
- start_addr  in  XLEN  first word address; low log2(XLEN/8) bits ignored (treated as 0).
- word_count  in  16  number of words to write; 0 is legal.
- s_valid / s_ready  in / out  1  byte-stream handshake.
- s_data  in  8  stream byte; little-endian within a word.
- a_valid / a_ready  out / in  1  TL A-channel handshake.
- a_opcode, a_param, a_size  out  3 each  always 0 (PutFullData), 0, and log2(XLEN/8).
- a_source  out  SID_WIDTH  SOURCE_ID.
- a_address  out  XLEN  current word address.
- a_mask  out  XLEN/8  all ones.
- a_data  out  XLEN  assembled word.
- d_valid / d_ready  in / out  1  TL D-channel handshake.
- d_opcode  in  3  response opcode.
- d_source  in  SID_WIDTH  response source ID.
- d_denied, d_corrupt  in  1 each  response status; d_corrupt is ignored for writes.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- error  out  1  sticky failure flag; cleared by the next accepted start.
- words_written  out  16  count of acknowledged words.

## Operation
- States: IDLE, COLLECT, REQ, RESP, DONE.
- IDLE:
  - On start, latch the address (aligned) and word_count; clear error and words_written; clear the byte index.
  - word_count==0 goes to DONE. Anything else goes to COLLECT.
- COLLECT:
  - s_ready=1.
  - Each s_valid&&s_ready writes s_data into byte lane [idx] of the word register, then increments idx.
  - Accepting byte XLEN/8-1 goes to REQ and resets idx to 0.
- REQ:
  - a_valid=1, with all A fields stable until a_valid&&a_ready.
  - On that handshake, go to RESP.
- RESP:
  - d_ready=1. On d_valid:
  - If d_denied, or d_opcode!=0 (AccessAck), or d_source!=SOURCE_ID: set error, go to IDLE, no done pulse.
  - Otherwise: words_written+=1 and address+=XLEN/8, wrapping modulo 2^XLEN. Go to DONE if words_written+1==word_count, else COLLECT.
- DONE: done=1 for exactly one cycle, then IDLE.
- Only one transaction is ever outstanding.
- start is ignored while busy.
- Stream bytes are never accepted outside COLLECT.

## Timing
- Reset values (all outputs 0 except fixed-constant fields):
  - busy=0, done=0, error=0, words_written=0, s_ready=0, a_valid=0, d_ready=0.
  - a_address=0, a_data=0.
  - a_mask=all ones, a_size=log2(XLEN/8), a_source=SOURCE_ID.
  - State is IDLE.
- Registered outputs only; no combinational path from s_valid, a_ready or d_valid to any output.
- start in cycle T gives busy=1 in T+1. With word_count≠0, s_ready=1 also in T+1.
- Final byte of a word accepted in cycle N gives a_valid=1 in N+1.
- a_ready in cycle M drops a_valid in M+1 and raises d_ready in M+1.
- d_valid accepted in cycle R:
  - Intermediate word: s_ready=1 in R+1.
  - Final word: done=1 in R+1, busy=0 in R+2.
- Minimum throughput: XLEN/8 + 2 cycles per word, with zero-wait stream and slave.
- A d_valid arriving in the same cycle d_ready first rises is accepted.
- Reset mid-operation:
  - Immediate return to IDLE. Any partial word and any in-flight transaction are abandoned.
  - The switch and memory must be reset in the same cycle.
- words_written rolls over modulo 2^16; this is unreachable because word_count≤65535.

## Test plan
- Reset: hold reset=0 for 3 cycles, then check every output is at its reset value and s_ready=0.
- Single word at XLEN=32:
  - start, start_addr=0x100, word_count=1; stream bytes 0x13,0x00,0x00,0x00.
  - Expect one PutFullData: address 0x100, data 0x00000013, mask 0xF, size 2.
  - Then done pulses one cycle and words_written=1.
- Multi-word with backpressure:
  - word_count=4, start_addr=0x0; memory holds a_ready low for 3 cycles per request.
  - Expect addresses 0x0,0x4,0x8,0xC in order, A fields stable while stalled, and memory[0..15] equal to the streamed bytes.
- Denied response:
  - Responder returns d_denied=1 on the 2nd of 3 words.
  - Expect error=1, no done, words_written=1, return to IDLE. The next start clears error.
- word_count=0: done pulses in cycle T+1 after start with no A-channel activity. start_addr=0x103 with word_count=1 writes to 0x100.
- Wrap and reset:
  - Wrap: start_addr=0xFFFFFFFC, word_count=2 gives addresses 0xFFFFFFFC then 0x00000000.
  - Reset: assert reset after 2 of 4 bytes. Expect no A-channel request; after release, state is IDLE and busy=0.
